// File: rtl/bcd_entry_pkg.sv
// Shared constants for the keypad BCD entry sequencer: key codes, FSM states, digit weights.
package bcd_entry_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_BKSP  = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hE;

  localparam int unsigned W_THOUSANDS = 1000;
  localparam int unsigned W_HUNDREDS  = 100;
  localparam int unsigned W_TENS      = 10;
  localparam int unsigned W_UNITS     = 1;

  typedef enum logic [1:0] {
    ENTRY = 2'd0,
    CONV  = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Index 0 is the least significant digit (d0).
  function automatic int unsigned digit_weight(input int idx);
    case (idx)
      3:       return W_THOUSANDS;
      2:       return W_HUNDREDS;
      1:       return W_TENS;
      default: return W_UNITS;
    endcase
  endfunction

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd4_to_bin.sv
// Combinational weighted sum of four BCD digits into an OUT_W-bit binary value.
module bcd4_to_bin
  import bcd_entry_pkg::*;
#(
  parameter int OUT_W = 14
) (
  input  logic [3:0]       d3,
  input  logic [3:0]       d2,
  input  logic [3:0]       d1,
  input  logic [3:0]       d0,
  output logic [OUT_W-1:0] bin
);

  logic [3:0]       dig  [4];
  logic [OUT_W-1:0] term [4];

  assign dig[0] = d0;
  assign dig[1] = d1;
  assign dig[2] = d2;
  assign dig[3] = d3;

  // Each term is widened before multiplying so the product is never truncated.
  for (genvar gi = 0; gi < 4; gi++) begin : g_term
    assign term[gi] = OUT_W'(dig[gi]) * OUT_W'(digit_weight(gi));
  end

  assign bin = term[3] + term[2] + term[1] + term[0];

endmodule

// File: rtl/bcd_entry_ctrl.sv
// Keypad digit entry, BCD-to-binary conversion with range check, valid/ready result output.
// Optional idle auto-clear is enabled by defining BCD_ENTRY_TIMEOUT_EN.
module bcd_entry_ctrl
  import bcd_entry_pkg::*;
#(
  parameter int OUT_W = 14,
  parameter int LIMIT = 9999
`ifdef BCD_ENTRY_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 50_000_000
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             key_ready,
  output logic [3:0]       d3,
  output logic [3:0]       d2,
  output logic [3:0]       d1,
  output logic [3:0]       d0,
  output logic [2:0]       digit_cnt,
  output logic [OUT_W-1:0] out_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err
);

  localparam logic [OUT_W-1:0] LIMIT_V = OUT_W'(LIMIT);

  state_e           state_q, state_d;
  logic [15:0]      digits_q, digits_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [OUT_W-1:0] out_bin_q, out_bin_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;
  logic [OUT_W-1:0] conv_value;
  logic             key_fire;

`ifdef BCD_ENTRY_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] idle_q, idle_d;
`endif

  bcd4_to_bin #(.OUT_W(OUT_W)) u_conv (
    .d3  (digits_q[15:12]),
    .d2  (digits_q[11:8]),
    .d1  (digits_q[7:4]),
    .d0  (digits_q[3:0]),
    .bin (conv_value)
  );

  assign key_ready = (state_q == ENTRY);
  assign key_fire  = key_valid && key_ready;

  always_comb begin
    state_d     = state_q;
    digits_d    = digits_q;
    cnt_d       = cnt_q;
    out_bin_d   = out_bin_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;
`ifdef BCD_ENTRY_TIMEOUT_EN
    idle_d      = idle_q;
`endif
    case (state_q)
      ENTRY: begin
`ifdef BCD_ENTRY_TIMEOUT_EN
        idle_d = idle_q + 1'b1;
`endif
        if (key_fire) begin
`ifdef BCD_ENTRY_TIMEOUT_EN
          idle_d = '0;
`endif
          if (is_digit(key_code)) begin
            if (cnt_q < 3'd4) begin
              digits_d = {digits_q[11:0], key_code};
              cnt_d    = cnt_q + 3'd1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            case (key_code)
              KEY_CLEAR: begin
                digits_d = '0;
                cnt_d    = '0;
              end
              KEY_BKSP: begin
                if (cnt_q != 3'd0) begin
                  digits_d = {4'd0, digits_q[15:4]};
                  cnt_d    = cnt_q - 3'd1;
                end
              end
              KEY_ENTER: state_d = CONV;
              default:   err_d = 1'b1;
            endcase
          end
        end
`ifdef BCD_ENTRY_TIMEOUT_EN
        // Idle expiry clears only when nothing was pressed this cycle.
        else if (idle_q == TO_W'(TIMEOUT_CYC - 1)) begin
          idle_d = '0;
          if (cnt_q != 3'd0) begin
            digits_d = '0;
            cnt_d    = '0;
          end
        end
`endif
      end
      CONV: begin
        if (conv_value <= LIMIT_V) begin
          out_bin_d   = conv_value;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          err_d   = 1'b1;
          state_d = ENTRY;
`ifdef BCD_ENTRY_TIMEOUT_EN
          idle_d  = '0;
`endif
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          digits_d    = '0;
          cnt_d       = '0;
          state_d     = ENTRY;
`ifdef BCD_ENTRY_TIMEOUT_EN
          idle_d      = '0;
`endif
        end
      end
      default: state_d = ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ENTRY;
      digits_q    <= '0;
      cnt_q       <= '0;
      out_bin_q   <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef BCD_ENTRY_TIMEOUT_EN
      idle_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      digits_q    <= digits_d;
      cnt_q       <= cnt_d;
      out_bin_q   <= out_bin_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
`ifdef BCD_ENTRY_TIMEOUT_EN
      idle_q      <= idle_d;
`endif
    end
  end

  assign d3        = digits_q[15:12];
  assign d2        = digits_q[11:8];
  assign d1        = digits_q[7:4];
  assign d0        = digits_q[3:0];
  assign digit_cnt = cnt_q;
  assign out_bin   = out_bin_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_entry_ctrl.sv
// Directed bench: instance 0 uses default LIMIT, instance 1 uses LIMIT=5000 (and the short timeout).
module tb_bcd_entry_ctrl;

  localparam int OUT_W = 14;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       key_valid;
  logic [3:0]       key_code  [2];
  logic [1:0]       key_ready;
  logic [3:0]       d3 [2], d2 [2], d1 [2], d0 [2];
  logic [2:0]       digit_cnt [2];
  logic [OUT_W-1:0] out_bin [2];
  logic [1:0]       out_valid;
  logic [1:0]       out_ready;
  logic [1:0]       err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_entry_ctrl #(.OUT_W(OUT_W), .LIMIT(9999)) u_a (
    .clk(clk), .rst(rst), .key_valid(key_valid[0]), .key_code(key_code[0]),
    .key_ready(key_ready[0]), .d3(d3[0]), .d2(d2[0]), .d1(d1[0]), .d0(d0[0]),
    .digit_cnt(digit_cnt[0]), .out_bin(out_bin[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .err(err[0])
  );

  bcd_entry_ctrl #(
    .OUT_W(OUT_W), .LIMIT(5000)
`ifdef BCD_ENTRY_TIMEOUT_EN
    , .TIMEOUT_CYC(16)
`endif
  ) u_b (
    .clk(clk), .rst(rst), .key_valid(key_valid[1]), .key_code(key_code[1]),
    .key_ready(key_ready[1]), .d3(d3[1]), .d2(d2[1]), .d1(d1[1]), .d0(d0[1]),
    .digit_cnt(digit_cnt[1]), .out_bin(out_bin[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .err(err[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // All tasks start and end at a falling edge; keys are accepted on the rising edge between.
  task automatic send_key(input int sel, input logic [3:0] code);
    key_valid[sel] = 1'b1;
    key_code[sel]  = code;
    @(negedge clk);
    key_valid[sel] = 1'b0;
  endtask

  task automatic send_seq(input int sel, input logic [3:0] codes [$]);
    foreach (codes[i]) send_key(sel, codes[i]);
  endtask

  task automatic check_digits(input string tag, input int sel, input logic [15:0] exp, input logic [2:0] exp_cnt);
    check({tag, ".digits"}, {16'd0, d3[sel], d2[sel], d1[sel], d0[sel]}, {16'd0, exp});
    check({tag, ".cnt"}, {29'd0, digit_cnt[sel]}, {29'd0, exp_cnt});
  endtask

  // Send ENTER, confirm the CONV gap, then the result one cycle later.
  task automatic enter_expect(input string tag, input int sel, input int exp_val);
    send_key(sel, 4'hE);
    check({tag, ".conv_gap"}, {31'd0, out_valid[sel]}, 32'd0);
    @(negedge clk);
    check({tag, ".out_valid"}, {31'd0, out_valid[sel]}, 32'd1);
    check({tag, ".out_bin"}, {18'd0, out_bin[sel]}, exp_val);
  endtask

  task automatic release_out(input string tag, input int sel);
    out_ready[sel] = 1'b1;
    @(negedge clk);
    out_ready[sel] = 1'b0;
    check({tag, ".rel_valid"}, {31'd0, out_valid[sel]}, 32'd0);
    check_digits({tag, ".rel"}, sel, 16'h0000, 3'd0);
    check({tag, ".rel_ready"}, {31'd0, key_ready[sel]}, 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    key_valid = '0;
    out_ready = '0;
    key_code[0] = '0;
    key_code[1] = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check_digits("reset", s, 16'h0000, 3'd0);
      check("reset.out_valid", {31'd0, out_valid[s]}, 32'd0);
      check("reset.out_bin", {18'd0, out_bin[s]}, 32'd0);
      check("reset.err", {31'd0, err[s]}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("reset.key_ready", {31'd0, key_ready[0]}, 32'd1);

    // 1234, held 5 cycles, keys ignored in HOLD
    send_seq(0, '{4'd1, 4'd2, 4'd3, 4'd4});
    check_digits("t1", 0, 16'h1234, 3'd4);
    enter_expect("t1", 0, 1234);
    key_valid[0] = 1'b1;
    key_code[0]  = 4'd5;
    repeat (5) @(negedge clk);
    check("t1.hold_ready", {31'd0, key_ready[0]}, 32'd0);
    check("t1.hold_valid", {31'd0, out_valid[0]}, 32'd1);
    check("t1.hold_bin", {18'd0, out_bin[0]}, 32'd1234);
    check_digits("t1.hold", 0, 16'h1234, 3'd4);
    key_valid[0] = 1'b0;
    release_out("t1", 0);

    // Fifth digit overflows; stray out_ready in ENTRY ignored
    send_seq(0, '{4'd9, 4'd8, 4'd7, 4'd6});
    check("t2.no_err", {31'd0, err[0]}, 32'd0);
    send_key(0, 4'd5);
    check("t2.err_pulse", {31'd0, err[0]}, 32'd1);
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    check("t2.err_cleared", {31'd0, err[0]}, 32'd0);
    check_digits("t2", 0, 16'h9876, 3'd4);
    enter_expect("t2", 0, 9876);
    release_out("t2", 0);

    // Backspace, then clear and empty entry
    send_seq(0, '{4'd4, 4'd2, 4'hB});
    check_digits("t3.bksp", 0, 16'h0004, 3'd1);
    send_key(0, 4'd7);
    enter_expect("t3", 0, 47);
    release_out("t3", 0);
    send_seq(0, '{4'd5, 4'hA});
    check_digits("t3.clear", 0, 16'h0000, 3'd0);
    enter_expect("t3.zero", 0, 0);
    release_out("t3.zero", 0);

    // Invalid code and backspace at empty
    send_seq(0, '{4'd3, 4'hC});
    check("t4.err_pulse", {31'd0, err[0]}, 32'd1);
    check_digits("t4", 0, 16'h0003, 3'd1);
    check("t4.key_ready", {31'd0, key_ready[0]}, 32'd1);
    send_seq(0, '{4'hB, 4'hB});
    check_digits("t4.bksp0", 0, 16'h0000, 3'd0);
    check("t4.bksp0_err", {31'd0, err[0]}, 32'd0);

    // Reset while holding a result
    send_key(0, 4'd8);
    enter_expect("t5", 0, 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5.rst_valid", {31'd0, out_valid[0]}, 32'd0);
    check_digits("t5.rst", 0, 16'h0000, 3'd0);

    // LIMIT=5000: over-range rejected with digits kept, boundary accepted
    send_seq(1, '{4'd6, 4'd0, 4'd0, 4'd0, 4'hE});
    @(negedge clk);
    check("t6.err_pulse", {31'd0, err[1]}, 32'd1);
    check("t6.no_valid", {31'd0, out_valid[1]}, 32'd0);
    check_digits("t6.kept", 1, 16'h6000, 3'd4);
    check("t6.key_ready", {31'd0, key_ready[1]}, 32'd1);
    send_key(1, 4'hB);
    check_digits("t6.bksp", 1, 16'h0600, 3'd3);
    enter_expect("t6", 1, 600);
    release_out("t6", 1);
    send_seq(1, '{4'd5, 4'd0, 4'd0, 4'd0});
    enter_expect("t6.limit", 1, 5000);
    check("t6.limit_err", {31'd0, err[1]}, 32'd0);
    release_out("t6.limit", 1);

`ifdef BCD_ENTRY_TIMEOUT_EN
    send_key(1, 4'd3);
    repeat (15) @(negedge clk);
    check("t7.before_to", {29'd0, digit_cnt[1]}, 32'd1);
    @(negedge clk);
    check_digits("t7.timeout", 1, 16'h0000, 3'd0);
    check("t7.no_err", {31'd0, err[1]}, 32'd0);
    send_key(1, 4'd1);
    repeat (9) @(negedge clk);
    send_key(1, 4'd2);
    repeat (9) @(negedge clk);
    send_key(1, 4'd3);
    repeat (9) @(negedge clk);
    check_digits("t7.kept", 1, 16'h0123, 3'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
